// File: rtl/imuldiv_muldiv_arbiter.sv
// imuldiv_muldiv_arbiter: round-robin sharing of one iterative mul/div unit between two requesters.
// Define IMULDIV_MULDIV_ARBITER_RESP_BUFFER_EN to register the unit result before returning it.
module imuldiv_muldiv_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  req0_msg_fn,
   input  logic [31:0] req0_msg_a,
   input  logic [31:0] req0_msg_b,
   input  logic        req0_val,
   output logic        req0_rdy,
   output logic [63:0] resp0_msg_result,
   output logic        resp0_val,
   input  logic        resp0_rdy,
   input  logic [2:0]  req1_msg_fn,
   input  logic [31:0] req1_msg_a,
   input  logic [31:0] req1_msg_b,
   input  logic        req1_val,
   output logic        req1_rdy,
   output logic [63:0] resp1_msg_result,
   output logic        resp1_val,
   input  logic        resp1_rdy,
   output logic [2:0]  muldivreq_msg_fn,
   output logic [31:0] muldivreq_msg_a,
   output logic [31:0] muldivreq_msg_b,
   output logic        muldivreq_val,
   input  logic        muldivreq_rdy,
   input  logic [63:0] muldivresp_msg_result,
   input  logic        muldivresp_val,
   output logic        muldivresp_rdy
);
`ifdef IMULDIV_MULDIV_ARBITER_RESP_BUFFER_EN
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   logic [63:0] result_q;
`else
   typedef enum logic [1:0] {IDLE, WAIT} state_t;
`endif
   state_t state;
   logic   owner, ptr, win, idle, waiting, owner_rdy, resp_val;
   // Pick the winner, steer its request to the unit and route the response back to the owner.
   always_comb begin
      win              = (req0_val && req1_val) ? ptr : req1_val;
      idle             = !reset && state == IDLE;
      waiting          = !reset && state == WAIT;
      owner_rdy        = owner ? resp1_rdy : resp0_rdy;
      muldivreq_msg_fn = win ? req1_msg_fn : req0_msg_fn;
      muldivreq_msg_a  = win ? req1_msg_a : req0_msg_a;
      muldivreq_msg_b  = win ? req1_msg_b : req0_msg_b;
      muldivreq_val    = idle && (req0_val || req1_val);
      req0_rdy         = idle && !win && muldivreq_rdy;
      req1_rdy         = idle && win && muldivreq_rdy;
`ifdef IMULDIV_MULDIV_ARBITER_RESP_BUFFER_EN
      resp_val         = !reset && state == RESP;
      resp0_msg_result = result_q;
      resp1_msg_result = result_q;
      muldivresp_rdy   = waiting;
`else
      resp_val         = waiting && muldivresp_val;
      resp0_msg_result = muldivresp_msg_result;
      resp1_msg_result = muldivresp_msg_result;
      muldivresp_rdy   = waiting && owner_rdy;
`endif
      resp0_val        = resp_val && !owner;
      resp1_val        = resp_val && owner;
   end
   // One transaction in flight; the pointer flips to the other port once the owner is answered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         owner <= 1'b0;
         ptr   <= 1'b0;
`ifdef IMULDIV_MULDIV_ARBITER_RESP_BUFFER_EN
         result_q <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (muldivreq_val && muldivreq_rdy) begin
               owner <= win;
               state <= WAIT;
            end
`ifdef IMULDIV_MULDIV_ARBITER_RESP_BUFFER_EN
            WAIT: if (muldivresp_val) begin
               result_q <= muldivresp_msg_result;
               state    <= RESP;
            end
            RESP: if (owner_rdy) begin
               ptr   <= !owner;
               state <= IDLE;
            end
`else
            WAIT: if (muldivresp_val && owner_rdy) begin
               ptr   <= !owner;
               state <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_imuldiv_muldiv_arbiter.sv
// tb_imuldiv_muldiv_arbiter: directed bench with a fixed-latency mul/div unit model behind the arbiter.
module tb_imuldiv_muldiv_arbiter;
   localparam int L = 3;
`ifdef IMULDIV_MULDIV_ARBITER_RESP_BUFFER_EN
   localparam int LAT = L + 2;
`else
   localparam int LAT = L + 1;
`endif
   logic        clk, reset;
   logic [2:0]  req0_msg_fn, req1_msg_fn, muldivreq_msg_fn;
   logic [31:0] req0_msg_a, req0_msg_b, req1_msg_a, req1_msg_b, muldivreq_msg_a, muldivreq_msg_b;
   logic        req0_val, req0_rdy, req1_val, req1_rdy, resp0_val, resp0_rdy, resp1_val, resp1_rdy;
   logic [63:0] resp0_msg_result, resp1_msg_result, muldivresp_msg_result;
   logic        muldivreq_val, muldivreq_rdy, muldivresp_val, muldivresp_rdy;
   logic        u_busy, u_val;
   logic [63:0] u_res;
   int          u_cnt, cyc, t_acc, passed, total;
   int          grants[$];

   imuldiv_muldiv_arbiter dut (
      .clk(clk), .reset(reset),
      .req0_msg_fn(req0_msg_fn), .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b),
      .req0_val(req0_val), .req0_rdy(req0_rdy),
      .resp0_msg_result(resp0_msg_result), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
      .req1_msg_fn(req1_msg_fn), .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b),
      .req1_val(req1_val), .req1_rdy(req1_rdy),
      .resp1_msg_result(resp1_msg_result), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
      .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
      .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val), .muldivreq_rdy(muldivreq_rdy),
      .muldivresp_msg_result(muldivresp_msg_result), .muldivresp_val(muldivresp_val),
      .muldivresp_rdy(muldivresp_rdy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic logic [63:0] muldiv(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
      if (fn == 3'd0) return {32'd0, a} * {32'd0, b};
      if (fn == 3'd1 || fn == 3'd2) return {32'd0, a / b};
      return {32'd0, a % b};
   endfunction

   // Unit model: accepts when empty, answers L cycles later, holds the answer until taken.
   assign muldivreq_rdy         = !u_busy && !u_val;
   assign muldivresp_val        = u_val;
   assign muldivresp_msg_result = u_res;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         u_busy <= 1'b0;
         u_val  <= 1'b0;
         u_cnt  <= 0;
      end else if (muldivreq_val && muldivreq_rdy) begin
         u_busy <= 1'b1;
         u_cnt  <= L - 1;
         u_res  <= muldiv(muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b);
      end else if (u_busy) begin
         if (u_cnt == 0) begin
            u_busy <= 1'b0;
            u_val  <= 1'b1;
         end else u_cnt <= u_cnt - 1;
      end else if (u_val && muldivresp_rdy) u_val <= 1'b0;
   end

   // Record when each request is accepted and which port won it.
   always @(negedge clk) begin
      if (muldivreq_val && muldivreq_rdy) begin
         t_acc = cyc;
         grants.push_back(req1_rdy ? 1 : 0);
      end
   end

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic hold_until_acc(input int p);
      bit done = 0;
      for (int i = 0; i < 60 && !done; i++) begin
         #1;
         done = p != 0 ? (req1_val && req1_rdy) : (req0_val && req0_rdy);
         step();
      end
      check($sformatf("acc%0d", p), 96'(done), 96'd1);
      if (p != 0) req1_val = 1'b0;
      else req0_val = 1'b0;
   endtask

   task automatic wait_resp(input int p, input logic [63:0] exp, input string tag);
      bit got = 0;
      int other = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         #1;
         if (p != 0 ? resp1_val : resp0_val) got = 1;
         else begin
            if (p != 0 ? resp0_val : resp1_val) other++;
            step();
         end
      end
      check({tag, "_seen"}, 96'(got), 96'd1);
      check({tag, "_result"}, 96'(p != 0 ? resp1_msg_result : resp0_msg_result), 96'(exp));
      check({tag, "_lat"}, 96'(cyc - t_acc), 96'(LAT));
      check({tag, "_other"}, 96'(other), 96'd0);
      step();
   endtask

   task automatic set_req(input int p, input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
      if (p != 0) begin
         req1_msg_fn = fn; req1_msg_a = a; req1_msg_b = b; req1_val = 1'b1;
      end else begin
         req0_msg_fn = fn; req0_msg_a = a; req0_msg_b = b; req0_val = 1'b1;
      end
   endtask

   initial begin
      int quiet;
      cyc = 0; t_acc = 0; passed = 0; total = 0;
      reset = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
      set_req(0, 3'd0, 32'd1, 32'd1);
      set_req(1, 3'd0, 32'd1, 32'd1);
      step();
      check("reset_outputs", 96'({req0_rdy, req1_rdy, muldivreq_val, muldivresp_rdy, resp0_val, resp1_val}), 96'd0);
      req0_val = 1'b0; req1_val = 1'b0;
      step();
      reset = 1'b0;
      step();
      // Single port multiply
      set_req(0, 3'd0, 32'd6, 32'd7);
      #1;
      check("t17_req_mux", 96'({req0_rdy, req1_rdy, muldivreq_val, muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b}),
            96'({1'b1, 1'b0, 1'b1, 3'd0, 32'd6, 32'd7}));
      hold_until_acc(0);
      wait_resp(0, 64'd42, "t17");
      // Tie straight after reset: port 0 first
      reset = 1'b1; step(); reset = 1'b0;
      set_req(0, 3'd1, 32'd100, 32'd7);
      set_req(1, 3'd3, 32'd100, 32'd7);
      #1;
      check("t18_tie", 96'({req0_rdy, req1_rdy, muldivreq_msg_fn}), 96'({1'b1, 1'b0, 3'd1}));
      hold_until_acc(0);
      wait_resp(0, 64'd14, "t18_r0");
      hold_until_acc(1);
      wait_resp(1, 64'd2, "t18_r1");
      // Fairness with both ports continuously valid
      step();
      grants.delete();
      set_req(0, 3'd0, 32'd2, 32'd3);
      set_req(1, 3'd0, 32'd4, 32'd5);
      for (int i = 0; i < 300 && grants.size() < 6; i++) step();
      req0_val = 1'b0; req1_val = 1'b0;
      begin
         logic [5:0] order = '1;
         for (int i = 0; i < 6 && i < grants.size(); i++) order[5-i] = grants[i][0];
         check("t19_order", 96'(order), 96'(6'b010101));
         check("t19_count", 96'(grants.size()), 96'd6);
      end
      for (int i = 0; i < 15; i++) step();
      // Response backpressure on port 1 while port 0 waits
      set_req(1, 3'd0, 32'd9, 32'd9);
      hold_until_acc(1);
      set_req(0, 3'd1, 32'd50, 32'd5);
      resp1_rdy = 1'b0;
      begin
         bit seen = 0;
         for (int i = 0; i < 60 && !seen; i++) begin
            #1;
            if (resp1_val) seen = 1;
            else begin
               check("t20_req0_blocked", 96'(req0_rdy), 96'd0);
               step();
            end
         end
         check("t20_seen", 96'(seen), 96'd1);
      end
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t20_hold%0d", i), 96'({resp1_val, req0_rdy, resp1_msg_result}), 96'({1'b1, 1'b0, 64'd81}));
         step();
      end
      resp1_rdy = 1'b1;
      step();
      check("t20_done", 96'({resp1_val, req0_rdy}), 96'(2'b01));
      hold_until_acc(0);
      wait_resp(0, 64'd10, "t20_r0");
      // Reset while waiting abandons the transaction
      set_req(1, 3'd0, 32'd3, 32'd5);
      hold_until_acc(1);
      reset = 1'b1;
      set_req(0, 3'd0, 32'd1, 32'd1);
      #1;
      check("t21_reset_outputs", 96'({req0_rdy, req1_rdy, muldivreq_val, muldivresp_rdy, resp0_val, resp1_val}), 96'd0);
      step();
      reset = 1'b0; req0_val = 1'b0;
      quiet = 0;
      for (int i = 0; i < 8; i++) begin
         if (resp0_val || resp1_val) quiet++;
         step();
      end
      check("t21_no_resp", 96'(quiet), 96'd0);
      set_req(1, 3'd0, 32'd3, 32'd5);
      #1;
      check("t21_idle", 96'({req1_rdy, muldivreq_val}), 96'(2'b11));
      hold_until_acc(1);
      wait_resp(1, 64'd15, "t21");
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
